// File: rtl/music_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | music_pkg : note encoding, frequency table, player states    |
// | Revision  : 1.0                                              |
// +--------------------------------------------------------------+
package music_pkg;

  localparam int NOTE_REST = 0;
  localparam int NOTE_MAX  = 47;
  localparam int NOTE_A4   = 22;

  // Equal-tempered pitches rounded to 1 Hz; index 0 is B2, index 22 is A4.
  localparam int NOTE_FREQ_HZ [48] = '{
     123,  131,  139,  147,  156,  165,  175,  185,  196,  208,  220,  233,
     247,  262,  277,  294,  311,  330,  349,  370,  392,  415,  440,  466,
     494,  523,  554,  587,  622,  659,  698,  740,  784,  831,  880,  932,
     988, 1047, 1109, 1175, 1245, 1319, 1397, 1480, 1568, 1661, 1760, 1865
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_PLAY  = 2'd3
  } player_state_t;

  function automatic int note_div(input int clk_hz, input int n);
    return (clk_hz + NOTE_FREQ_HZ[n]) / (2 * NOTE_FREQ_HZ[n]);
  endfunction

  // The lowest note has the largest half-period divisor.
  function automatic int div_width(input int clk_hz);
    return $clog2(note_div(clk_hz, 0) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/music_player_tone_gen.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tone_gen : half-period counter driving a registered square   |
// | Revision : 1.0                                               |
// +--------------------------------------------------------------+
module tone_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  input  logic             restart,
  output logic             wave
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_wave;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (restart || !en) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (r_cnt == div - 1'b1) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign wave = r_wave;

endmodule
`default_nettype wire

// File: rtl/music_player.sv
`default_nettype none
// +--------------------------------------------------------------+
// | music_player : steps the note ROM at a fixed tempo, buzzer   |
// | Revision     : 1.0                                           |
// +--------------------------------------------------------------+
module music_player
  import music_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int STEP_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000,
  parameter int SONG_LEN   = 242
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_note,
  output logic       buzzer,
  output logic       playing,
  output logic       done
);

  localparam int c_div_w  = div_width(CLK_HZ);
  localparam int c_step_w = $clog2(STEP_TICKS + 1);
  localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_TICKS - 1);
  // Registered buzzer: stop enabling one cycle early so the gap starts exactly on time.
  localparam logic [c_step_w-1:0] c_tone_end  = c_step_w'(STEP_TICKS - GAP_TICKS - 1);
  localparam logic [7:0]          c_addr_last = 8'(SONG_LEN - 1);

  player_state_t         r_state, w_state_nxt;
  logic [c_step_w-1:0]   r_step;
  logic [7:0]            r_addr;
  logic [7:0]            r_note;
  logic [c_div_w-1:0]    r_div;
  logic                  r_done;
  logic                  w_step_end, w_last, w_audible, w_tone_en;
  logic [c_div_w-1:0]    w_div_sel;
  logic [c_div_w-1:0]    w_div_tbl [64];

  for (genvar i = 0; i < 64; i++) begin : g_div
    if (i <= NOTE_MAX) begin : g_note
      assign w_div_tbl[i] = c_div_w'(note_div(CLK_HZ, i));
    end else begin : g_rest
      assign w_div_tbl[i] = '0;
    end
  end

  assign w_div_sel  = (rom_note <= 8'(NOTE_MAX)) ? w_div_tbl[rom_note[5:0]] : '0;
  assign w_step_end = (r_state == ST_PLAY) && (r_step == c_step_last);
  assign w_last     = (r_addr == c_addr_last);
  assign w_audible  = (r_note != 8'(NOTE_REST)) && (r_note <= 8'(NOTE_MAX));
  assign w_tone_en  = (r_state == ST_PLAY) && (r_step < c_tone_end) && w_audible && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_PLAY;
      ST_PLAY:  if (w_step_end) w_state_nxt = (w_last && !loop_en) ? ST_IDLE : ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (stop) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
      r_addr <= '0;
      r_note <= '0;
      r_div  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop || r_state == ST_IDLE) begin
        r_step <= '0;
        r_addr <= '0;
      end else if (w_step_end) begin
        r_step <= '0;
        if (w_last) begin
          r_addr <= '0;
          r_done <= !loop_en;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end else begin
        r_step <= r_step + 1'b1;
      end
      if (r_state == ST_LATCH) begin
        r_note <= rom_note;
        r_div  <= w_div_sel;
      end
    end
  end

  tone_gen #(.DIV_W(c_div_w)) u_tone (
    .clk     (clk),
    .rst     (rst),
    .div     (r_div),
    .en      (w_tone_en),
    .restart (r_state == ST_LATCH),
    .wave    (buzzer)
  );

  assign rom_addr = r_addr;
  assign playing  = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule
`default_nettype wire
